// File: rtl/shift32_seq_if.sv
// Handshake/data bundle for the sequential shifter.
//   start  : request a new shift (taken only while ready=1)
//   op     : 00 SLL, 01 SRL, 10 SRA, 11 PASS
//   in0    : operand, sampled at accept
//   shamt  : shift amount 0-31, sampled at accept
//   ready  : block idle and able to accept start
//   done   : one-cycle pulse, out carries the final result
//   out    : result register
interface shift32_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] in0;
    logic [4:0]  shamt;
    logic        ready;
    logic        done;
    logic [31:0] out;

    modport master (output start, op, in0, shamt, input ready, done, out);
    modport slave  (input start, op, in0, shamt, output ready, done, out);
endinterface

// File: rtl/shift32_seq.sv
// Sequential one-bit-per-cycle 32-bit shifter (SLL/SRL/SRA/PASS).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : shift32_seq_if.slave (start/op/in0/shamt in, ready/done/out out)
// An accepted request takes 1+shamt cycles to done (1 cycle for PASS or
// shamt=0). ready and done are registered FSM outputs.
module shift32_seq (
    input  logic          clk,
    input  logic          rst,
    shift32_seq_if.slave  bus
);
    localparam int DATA_W = 32;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    logic [4:0]          count;
    logic [1:0]          op_r;
    logic [DATA_W-1:0]   out_r;
    logic                done_r;
    logic                ready_r;

    // Single-bit step of the selected operation.
    function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] v,
                                                    input logic [1:0] o);
        logic signed [DATA_W-1:0] s;
        s = v;
        case (o)
            OP_SLL:  return v << 1;
            OP_SRL:  return v >> 1;
            OP_SRA:  return $unsigned(s >>> 1);
            default: return v;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= 5'd0;
            op_r    <= OP_SLL;
            out_r   <= '0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok()) begin
                        out_r   <= bus.in0;
                        count   <= bus.shamt;
                        op_r    <= bus.op;
                        ready_r <= 1'b0;
                        // Nothing to shift: go straight to the result cycle.
                        if (bus.shamt == 5'd0 || bus.op == OP_PASS) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    out_r <= shift_one(out_r, op_r);
                    count <= count - 5'd1;
                    if (count == 5'd1) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // start is only honoured while the registered ready is high.
    function automatic logic start_ok();
        return bus.start && ready_r;
    endfunction

    assign bus.out   = out_r;
    assign bus.done  = done_r;
    assign bus.ready = ready_r;
endmodule

// File: tb/tb_shift32_seq.sv
module tb_shift32_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] out;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    shift32_seq_if bus();

    shift32_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with out %h expected no pulse (cycle %0d)",
                         bus.out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_out", bus.out, e.out);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one request at the current negedge and follow it to the first
    // IDLE cycle after done. glitch>0 pulses a spurious start (in0=0)
    // that many cycles after accept.
    task automatic run(input logic [1:0] o, input logic [31:0] a,
                       input logic [4:0] s, input logic [31:0] exp_out,
                       input int lat, input int glitch);
        exp_t e;
        check("ready_at_accept", {31'd0, bus.ready}, 32'd1);
        bus.start = 1'b1;
        bus.op    = o;
        bus.in0   = a;
        bus.shamt = s;
        e.out = exp_out;
        e.cyc = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        bus.in0   = ~a;
        bus.op    = ~o;
        bus.shamt = ~s;
        for (int k = 1; k <= lat; k++) begin
            bus.start = (k == glitch);
            if (k == glitch) bus.in0 = 32'h0;
            check("ready_busy", {31'd0, bus.ready}, 32'd0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("ready_after", {31'd0, bus.ready}, 32'd1);
    endtask

    task automatic idle(input int n, input logic [31:0] hold);
        for (int k = 0; k < n; k++) begin
            check("idle_out_hold", bus.out, hold);
            check("idle_ready", {31'd0, bus.ready}, 32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.in0   = 32'h0;
        bus.shamt = 5'd0;
        rst       = 1'b1;

        @(negedge clk);
        check("reset_out", bus.out, 32'h0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_ready", {31'd0, bus.ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", {31'd0, bus.ready}, 32'd1);

        // SLL full width
        run(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, 0);
        // SRA / SRL of MSB-set operand, SRA of positive operand
        run(2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000, 5, 0);
        run(2'b01, 32'h8000_0000, 5'd4, 32'h0800_0000, 5, 0);
        run(2'b10, 32'h7000_0000, 5'd4, 32'h0700_0000, 5, 0);
        // shamt=0 and PASS
        run(2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, 0);
        run(2'b11, 32'hDEAD_BEEF, 5'd7, 32'hDEAD_BEEF, 1, 0);
        // SRL with an ignored start mid-operation, then result holds
        run(2'b01, 32'hFFFF_FFFF, 5'd8, 32'h00FF_FFFF, 9, 3);
        idle(3, 32'h00FF_FFFF);

        // Reset in the middle of a long SLL: no done may follow
        check("ready_before_abort", {31'd0, bus.ready}, 32'd1);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.in0   = 32'h0000_0001;
        bus.shamt = 5'd20;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out", bus.out, 32'h0);
        check("abort_ready", {31'd0, bus.ready}, 32'd1);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        idle(25, 32'h0);

        // Reset wins over a simultaneous start
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.in0   = 32'hDEAD_BEEF;
        bus.shamt = 5'd0;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_prio_out", bus.out, 32'h0);
        check("rst_prio_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_prio_done", {31'd0, bus.done}, 32'd0);
        idle(3, 32'h0);

        // Normal operation after reset
        run(2'b00, 32'h0000_0003, 5'd4, 32'h0000_0030, 5, 0);
        // Back-to-back: second request in the first IDLE cycle after done
        run(2'b10, 32'h8000_0001, 5'd1, 32'hC000_0000, 2, 0);
        run(2'b00, 32'h0000_000F, 5'd3, 32'h0000_0078, 4, 0);
        idle(2, 32'h0000_0078);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift32_seq.md
SHIFT32_SEQ -- requirements
Module: shift32_seq

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port start  input  1  request a new shift; accepted only in a cycle where ready=1.
REQ-005 Port op  input  2  operation: 2'b00 SLL, 2'b01 SRL, 2'b10 SRA, 2'b11 PASS.
REQ-006 Port in0  input  32  operand to shift; sampled at accept.
REQ-007 Port shamt  input  5  shift amount 0-31; sampled at accept.
REQ-008 Port ready  output  1  high only in IDLE; block can accept start.
REQ-009 Port done  output  1  one-cycle pulse; out holds the final result in this cycle.
REQ-010 Port out  output  32  result register.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1: latch in0 into the result register, shamt into a 5-bit count, and op into a 2-bit register.
REQ-013 At accept, the next state SHALL be DONE if shamt=0 or op=PASS; otherwise it SHALL be SHIFT.
REQ-014 Each SHIFT cycle SHALL shift the result register by exactly one bit and decrement count by 1.
REQ-015 SHIFT with count=1 SHALL perform its final shift and transition to DONE.
REQ-016 SLL SHALL shift left and fill with 0.
REQ-017 SRL SHALL shift right and fill with 0.
REQ-018 SRA SHALL shift right and fill with the current bit 31.
REQ-019 Latency: for an accept in cycle T, done=1 SHALL occur in cycle T+1+shamt; for PASS or shamt=0, done SHALL occur in cycle T+1.
REQ-020 DONE SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-021 ready SHALL be 0 in SHIFT and DONE.
REQ-022 start SHALL be ignored while ready=0, with no effect on the operation in progress.
REQ-023 out is intermediate while in SHIFT; it is valid only when done=1.
REQ-024 After DONE, out SHALL hold the result until the next accepted start.
REQ-025 Changes on in0, shamt and op after accept SHALL NOT affect the operation in progress.
REQ-026 Back-to-back: a start in the first IDLE cycle after DONE SHALL be accepted; minimum spacing between accepts is shamt+2 cycles.

Reset
REQ-027 rst=1 at a clock edge SHALL force, in any state, mid-operation included: state=IDLE, count=0, out=32'h0000_0000, done=0.
REQ-028 In the cycle after reset, ready SHALL be 1.
REQ-029 rst SHALL take priority over start in the same cycle; no accept occurs.
REQ-030 Reset during SHIFT SHALL abandon the operation; no done pulse SHALL follow for it.

Verification
REQ-031 SLL, in0=32'h0000_0001, shamt=31, start at T -> done=1 only at T+32, out=32'h8000_0000, ready=0 during T+1..T+32, ready=1 at T+33.
REQ-032 SRA, in0=32'h8000_0000, shamt=4 -> done at T+5, out=32'hF800_0000; SRL with the same operands -> out=32'h0800_0000.
REQ-033 SLL, in0=32'hDEAD_BEEF, shamt=0; then PASS, shamt=7 -> each gives done at T+1, out=32'hDEAD_BEEF.
REQ-034 SRL, in0=32'hFFFF_FFFF, shamt=8 -> done at T+9, out=32'h00FF_FFFF.
REQ-034a During that operation, start pulses at T+3 with in0=0 -> ignored, and no second done pulse.
REQ-035 SLL, shamt=20, rst pulsed at T+5 -> at T+6 out=0, ready=1, done=0.
REQ-035a After that reset, a new start -> completes normally with correct latency.
REQ-036 Back-to-back: SRA, in0=32'h8000_0001, shamt=1, accept at T -> done at T+2, out=32'hC000_0000.
REQ-036a Second start at T+3 -> accepted; done at T+3+1+shamt2.
